// File: rtl/uart2i2c_pkg.sv
// Shared constants for the UART2I2C bridge: sync bytes, status codes,
// command bit positions and the one-hot parser state encoding.
package uart2i2c_pkg;

    localparam logic [7:0] SYNC_RX = 8'hA5;
    localparam logic [7:0] SYNC_TX = 8'h5A;

    localparam logic [7:0] STAT_OK   = 8'h00;
    localparam logic [7:0] STAT_NACK = 8'h01;
    localparam logic [7:0] STAT_CHK  = 8'h02;
    localparam logic [7:0] STAT_BAD  = 8'h03;

    localparam int CMD_RD  = 0;
    localparam int CMD_A16 = 1;
    localparam int CMD_CFG = 2;

    localparam int S_HUNT  = 0;
    localparam int S_CMD   = 1;
    localparam int S_BODY  = 2;
    localparam int S_CHKB  = 3;
    localparam int S_ISSUE = 4;
    localparam int S_WAIT  = 5;
    localparam int S_TXH   = 6;
    localparam int S_TXS   = 7;
    localparam int S_TXD   = 8;

    localparam logic [8:0] ST_HUNT  = 9'b0_0000_0001;
    localparam logic [8:0] ST_CMD   = 9'b0_0000_0010;
    localparam logic [8:0] ST_BODY  = 9'b0_0000_0100;
    localparam logic [8:0] ST_CHKB  = 9'b0_0000_1000;
    localparam logic [8:0] ST_ISSUE = 9'b0_0001_0000;
    localparam logic [8:0] ST_WAIT  = 9'b0_0010_0000;
    localparam logic [8:0] ST_TXH   = 9'b0_0100_0000;
    localparam logic [8:0] ST_TXS   = 9'b0_1000_0000;
    localparam logic [8:0] ST_TXD   = 9'b1_0000_0000;

    function automatic logic cmd_bad(input logic [7:0] c);
        return (c[7:3] != 5'd0) || (c[CMD_CFG] && (c[1:0] != 2'd0));
    endfunction

endpackage

// File: rtl/uart_gap_timer.sv
// Inter-byte gap counter: counts enabled idle cycles and pulses expire_o
// on the cycle the gap reaches LIMIT.
module uart_gap_timer #(
    parameter logic [31:0] LIMIT = 32'd500000
) (
    input  logic Clk,
    input  logic Rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    logic [31:0] cnt_q;

    assign expire_o = en_i && !clr_i && (cnt_q == LIMIT - 32'd1);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            cnt_q <= 32'd0;
        end else if (clr_i || !en_i) begin
            cnt_q <= 32'd0;
        end else begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

endmodule

// File: rtl/uart_i2c_cmd_parser.sv
// Host command framer for UART2I2C: parses A5-framed commands, issues
// single-register I2C requests and returns 5A-framed status responses.
module uart_i2c_cmd_parser
    import uart2i2c_pkg::*;
#(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd500000,
    parameter logic [31:0] DLY_DEFAULT    = 32'd1000
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        wrreg_req,
    output logic        rdreg_req,
    output logic [15:0] addr,
    output logic        addr_mode,
    output logic [7:0]  wrdata,
    output logic [7:0]  device_id,
    output logic [31:0] dly_cnt_max,
    input  logic [7:0]  rddata,
    input  logic        ack,
    input  logic        RW_Done,
    output logic        busy
);

    logic [8:0]       state_q, state_d;
    logic [2:0]       cmd_q, cmd_d;
    logic [3:0][7:0]  body_q, body_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [7:0]       chk_q, chk_d;
    logic [7:0]       status_q, status_d;
    logic [7:0]       rdbuf_q, rdbuf_d;
    logic             has_data_q, has_data_d;
    logic [31:0]      dly_q, dly_d;
    logic [15:0]      addr_q, addr_d;
    logic             amode_q, amode_d;
    logic [7:0]       wrdata_q, wrdata_d;
    logic [7:0]       dev_q, dev_d;
    logic             wr_q, wr_d;
    logic             rd_q, rd_d;
    logic             gap_en;
    logic             gap_expire;
    logic [1:0]       last_idx;

    assign gap_en   = state_q[S_CMD] | state_q[S_BODY] | state_q[S_CHKB];
    assign last_idx = cmd_q[CMD_RD] ? 2'd2 : 2'd3;

    uart_gap_timer #(
        .LIMIT    (TIMEOUT_CYCLES)
    ) u_gap (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .clr_i    (rx_valid),
        .en_i     (gap_en),
        .expire_o (gap_expire)
    );

    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        body_d     = body_q;
        cnt_d      = cnt_q;
        chk_d      = chk_q;
        status_d   = status_q;
        rdbuf_d    = rdbuf_q;
        has_data_d = has_data_q;
        dly_d      = dly_q;
        addr_d     = addr_q;
        amode_d    = amode_q;
        wrdata_d   = wrdata_q;
        dev_d      = dev_q;
        wr_d       = 1'b0;
        rd_d       = 1'b0;
        unique case (1'b1)
            state_q[S_HUNT]: begin
                if (rx_valid && rx_data == SYNC_RX) begin
                    chk_d   = 8'h00;
                    cnt_d   = 2'd0;
                    state_d = ST_CMD;
                end
            end
            state_q[S_CMD]: begin
                if (rx_valid) begin
                    cmd_d = rx_data[2:0];
                    chk_d = chk_q ^ rx_data;
                    if (cmd_bad(rx_data)) begin
                        status_d   = STAT_BAD;
                        has_data_d = 1'b0;
                        state_d    = ST_TXH;
                    end else begin
                        state_d = ST_BODY;
                    end
                end else if (gap_expire) begin
                    state_d = ST_HUNT;
                end
            end
            state_q[S_BODY]: begin
                if (rx_valid) begin
                    body_d[cnt_q] = rx_data;
                    chk_d         = chk_q ^ rx_data;
                    cnt_d         = cnt_q + 2'd1;
                    if (cnt_q == last_idx) begin
                        state_d = ST_CHKB;
                    end
                end else if (gap_expire) begin
                    state_d = ST_HUNT;
                end
            end
            state_q[S_CHKB]: begin
                if (rx_valid) begin
                    if (rx_data != chk_q) begin
                        status_d   = STAT_CHK;
                        has_data_d = 1'b0;
                        state_d    = ST_TXH;
                    end else if (cmd_q[CMD_CFG]) begin
                        // D3 arrives first, so body byte 0 is the MSB
                        dly_d      = {body_q[0], body_q[1],
                                      body_q[2], body_q[3]};
                        status_d   = STAT_OK;
                        has_data_d = 1'b0;
                        state_d    = ST_TXH;
                    end else begin
                        dev_d      = {body_q[0][7:1], 1'b0};
                        addr_d     = cmd_q[CMD_A16] ?
                                     {body_q[1], body_q[2]} :
                                     {8'h00, body_q[2]};
                        amode_d    = cmd_q[CMD_A16];
                        wrdata_d   = cmd_q[CMD_RD] ? wrdata_q : body_q[3];
                        wr_d       = !cmd_q[CMD_RD];
                        rd_d       = cmd_q[CMD_RD];
                        has_data_d = cmd_q[CMD_RD];
                        state_d    = ST_ISSUE;
                    end
                end else if (gap_expire) begin
                    state_d = ST_HUNT;
                end
            end
            state_q[S_ISSUE]: begin
                state_d = ST_WAIT;
            end
            state_q[S_WAIT]: begin
                if (RW_Done) begin
                    status_d = ack ? STAT_NACK : STAT_OK;
                    rdbuf_d  = rddata;
                    state_d  = ST_TXH;
                end
            end
            state_q[S_TXH]: begin
                if (tx_ready) begin
                    state_d = ST_TXS;
                end
            end
            state_q[S_TXS]: begin
                if (tx_ready) begin
                    state_d = has_data_q ? ST_TXD : ST_HUNT;
                end
            end
            state_q[S_TXD]: begin
                if (tx_ready) begin
                    state_d = ST_HUNT;
                end
            end
            default: begin
                state_d = ST_HUNT;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q    <= ST_HUNT;
            cmd_q      <= 3'd0;
            body_q     <= '0;
            cnt_q      <= 2'd0;
            chk_q      <= 8'h00;
            status_q   <= 8'h00;
            rdbuf_q    <= 8'h00;
            has_data_q <= 1'b0;
            dly_q      <= DLY_DEFAULT;
            addr_q     <= 16'h0000;
            amode_q    <= 1'b0;
            wrdata_q   <= 8'h00;
            dev_q      <= 8'h00;
            wr_q       <= 1'b0;
            rd_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            body_q     <= body_d;
            cnt_q      <= cnt_d;
            chk_q      <= chk_d;
            status_q   <= status_d;
            rdbuf_q    <= rdbuf_d;
            has_data_q <= has_data_d;
            dly_q      <= dly_d;
            addr_q     <= addr_d;
            amode_q    <= amode_d;
            wrdata_q   <= wrdata_d;
            dev_q      <= dev_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
        end
    end

    assign tx_valid    = state_q[S_TXH] | state_q[S_TXS] | state_q[S_TXD];
    assign tx_data     = state_q[S_TXH] ? SYNC_TX  :
                         state_q[S_TXS] ? status_q :
                         state_q[S_TXD] ? rdbuf_q  : 8'h00;
    assign wrreg_req   = wr_q;
    assign rdreg_req   = rd_q;
    assign addr        = addr_q;
    assign addr_mode   = amode_q;
    assign wrdata      = wrdata_q;
    assign device_id   = dev_q;
    assign dly_cnt_max = dly_q;
    assign busy        = !state_q[S_HUNT];

endmodule

// File: tb/tb_uart_i2c_cmd_parser.sv
// Randomised scoreboard bench for uart_i2c_cmd_parser with a frame-level
// reference model, an I2C responder and a UART TX sink with backpressure.
module tb_uart_i2c_cmd_parser;

    localparam int          TMO  = 64;
    localparam logic [31:0] DLYD = 32'd1000;

    typedef logic [7:0] byte_t;
    typedef struct {
        logic        wr;
        logic [7:0]  dev;
        logic [15:0] addr;
        logic        amode;
        logic [7:0]  wd;
    } req_t;
    typedef struct {
        logic       ack;
        logic [7:0] rdd;
        int         dly;
    } plan_t;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        wrreg_req;
    logic        rdreg_req;
    logic [15:0] addr;
    logic        addr_mode;
    logic [7:0]  wrdata;
    logic [7:0]  device_id;
    logic [31:0] dly_cnt_max;
    logic [7:0]  rddata;
    logic        ack;
    logic        RW_Done;
    logic        busy;

    always #5 Clk = ~Clk;

    uart_i2c_cmd_parser #(
        .TIMEOUT_CYCLES (TMO),
        .DLY_DEFAULT    (DLYD)
    ) dut (
        .Clk         (Clk),
        .Rst_n       (Rst_n),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .wrreg_req   (wrreg_req),
        .rdreg_req   (rdreg_req),
        .addr        (addr),
        .addr_mode   (addr_mode),
        .wrdata      (wrdata),
        .device_id   (device_id),
        .dly_cnt_max (dly_cnt_max),
        .rddata      (rddata),
        .ack         (ack),
        .RW_Done     (RW_Done),
        .busy        (busy)
    );

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    int n_assert = 0;
    int n_fail   = 0;

    byte_t       exp_tx[$];
    req_t        exp_req[$];
    plan_t       plans[$];
    bit          exp_rise[$];
    logic [31:0] m_dly;
    int          drv_cyc  = 0;
    int          rsp_trig = 0;
    bit          rsp_wait = 1'b0;
    int          stray_req  = 0;
    int          stray_done = 0;
    bit          bp_mode = 1'b0;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic fail(input string nm);
        n_assert++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", nm, cyc);
    endtask

    // Reference model: whole-frame semantics from the command rules.
    task automatic model_frame(input byte_t f[$], input logic a,
                               input byte_t rdd, input int dly);
        byte_t c, x, d;
        int    n;
        req_t  r;
        plan_t p;
        c = f[1];
        if (c[7:3] != 0 || (c[2] && c[1:0] != 0)) begin
            exp_tx.push_back(8'h5A);
            exp_tx.push_back(8'h03);
            exp_rise.push_back(1'b0);
            return;
        end
        n = c[0] ? 6 : 7;
        x = 8'h00;
        for (int i = 1; i < n - 1; i++) x ^= f[i];
        exp_tx.push_back(8'h5A);
        if (f[n-1] != x) begin
            exp_tx.push_back(8'h02);
            exp_rise.push_back(1'b0);
        end else if (c[2]) begin
            m_dly = {f[2], f[3], f[4], f[5]};
            exp_tx.push_back(8'h00);
            exp_rise.push_back(1'b0);
        end else begin
            d       = f[2];
            r.wr    = !c[0];
            r.dev   = {d[7:1], 1'b0};
            r.addr  = c[1] ? {f[3], f[4]} : {8'h00, f[4]};
            r.amode = c[1];
            r.wd    = c[0] ? 8'h00 : f[5];
            exp_req.push_back(r);
            p.ack = a;
            p.rdd = rdd;
            p.dly = dly;
            plans.push_back(p);
            exp_tx.push_back({7'b0, a});
            if (c[0]) exp_tx.push_back(rdd);
            exp_rise.push_back(1'b1);
        end
    endtask

    task automatic build(input int kind, output byte_t f[$]);
        byte_t c, x, b;
        int    nb;
        f = {};
        f.push_back(8'hA5);
        if (kind == 3) begin
            do c = 8'($urandom);
            while (!(c[7:3] != 0 || (c[2] && c[1:0] != 0)));
            f.push_back(c);
        end else begin
            if (kind == 2)      c = 8'h04;
            else if (kind == 0) c = {6'b0, 1'($urandom), 1'b0};
            else if (kind == 1) c = {6'b0, 1'($urandom), 1'b1};
            else                c = {6'b0, 2'($urandom)};
            nb = c[0] ? 3 : 4;
            f.push_back(c);
            x = c;
            repeat (nb) begin
                b = 8'($urandom);
                f.push_back(b);
                x ^= b;
            end
            if (kind == 4) x ^= 8'(1 << $urandom_range(0, 7));
            f.push_back(x);
        end
    endtask

    task automatic send_byte(input byte_t b, input int gap);
        rx_data  = b;
        rx_valid = 1'b1;
        drv_cyc  = cyc;
        @(posedge Clk); #1;
        rx_valid = 1'b0;
        repeat (gap) begin
            @(posedge Clk); #1;
        end
    endtask

    task automatic send_frame(input byte_t f[$]);
        foreach (f[i]) send_byte(f[i], (i == f.size() - 1) ? 0 :
                                 $urandom_range(0, 4));
    endtask

    task automatic wait_idle(input string nm);
        int t;
        t = 0;
        while ((exp_tx.size() != 0 || busy || rsp_wait) && t < 3000) begin
            @(posedge Clk); #1;
            t++;
        end
        if (t >= 3000) fail({nm, " timed out waiting for response"});
        check({nm, " req queue drained"}, 32'(exp_req.size()), 32'd0);
        check({nm, " rise queue drained"}, 32'(exp_rise.size()), 32'd0);
    endtask

    // I2C side: answers each request after its planned delay.
    initial begin
        plan_t cur;
        int    cnt;
        RW_Done = 1'b0;
        ack     = 1'b0;
        rddata  = 8'h00;
        cnt     = 0;
        forever begin
            @(posedge Clk); #1;
            RW_Done = 1'b0;
            ack     = 1'($urandom);
            rddata  = 8'($urandom);
            if (!Rst_n) begin
                rsp_wait = 1'b0;
            end else if (rsp_wait) begin
                if (cnt == 0) begin
                    RW_Done  = 1'b1;
                    ack      = cur.ack;
                    rddata   = cur.rdd;
                    rsp_wait = 1'b0;
                    rsp_trig = cyc;
                end else begin
                    cnt--;
                end
            end else if ((wrreg_req || rdreg_req) && plans.size() > 0) begin
                cur      = plans.pop_front();
                cnt      = cur.dly;
                rsp_wait = 1'b1;
            end else if (stray_done < stray_req) begin
                RW_Done = 1'b1;
                stray_done++;
            end
        end
    end

    // UART TX sink: random ready, or 20 stalled cycles per byte.
    initial begin
        int stall;
        tx_ready = 1'b0;
        stall    = 0;
        forever begin
            @(posedge Clk); #1;
            if (!bp_mode) begin
                tx_ready = ($urandom_range(0, 3) != 0);
            end else if (tx_ready) begin
                tx_ready = 1'b0;
                stall    = 0;
            end else if (tx_valid) begin
                stall++;
                if (stall >= 20) tx_ready = 1'b1;
            end
        end
    end

    logic  pv = 1'b0, pr = 1'b0, preq = 1'b0;
    byte_t pd = 8'h00;

    always @(negedge Clk) begin : monitor
        bit   k;
        req_t r;
        if (!Rst_n) begin
            pv   = 1'b0;
            pr   = 1'b0;
            preq = 1'b0;
        end else begin
            if (tx_valid && !pv) begin
                if (exp_rise.size() == 0) begin
                    fail("unexpected tx_valid rise");
                end else begin
                    k = exp_rise.pop_front();
                    check("tx_valid latency", 32'(cyc),
                          32'((k ? rsp_trig : drv_cyc) + 1));
                end
            end
            if (pv && !pr) begin
                check("tx_valid held", 32'(tx_valid), 32'd1);
                check("tx_data stable", 32'(tx_data), 32'(pd));
            end
            if (tx_valid && tx_ready) begin
                if (exp_tx.size() == 0) fail("unexpected tx byte");
                else check("tx byte", 32'(tx_data), 32'(exp_tx.pop_front()));
            end
            if (wrreg_req || rdreg_req) begin
                if (preq) fail("req pulse longer than one cycle");
                if (exp_req.size() == 0) begin
                    fail("unexpected req");
                end else begin
                    r = exp_req.pop_front();
                    check("wrreg_req", 32'(wrreg_req), 32'(r.wr));
                    check("rdreg_req", 32'(rdreg_req), 32'(!r.wr));
                    check("device_id", 32'(device_id), 32'(r.dev));
                    check("addr", 32'(addr), 32'(r.addr));
                    check("addr_mode", 32'(addr_mode), 32'(r.amode));
                    if (r.wr) check("wrdata", 32'(wrdata), 32'(r.wd));
                    check("req latency", 32'(cyc), 32'(drv_cyc + 1));
                end
            end
            pv   = tx_valid;
            pr   = tx_ready;
            pd   = tx_data;
            preq = wrreg_req || rdreg_req;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        byte_t       f[$];
        byte_t       g;
        logic [31:0] old;
        int          kind, t;
        Rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        m_dly    = DLYD;
        repeat (3) @(posedge Clk);
        #1;
        check("reset tx_valid", 32'(tx_valid), 32'd0);
        check("reset tx_data", 32'(tx_data), 32'd0);
        check("reset wrreg_req", 32'(wrreg_req), 32'd0);
        check("reset rdreg_req", 32'(rdreg_req), 32'd0);
        check("reset addr", 32'(addr), 32'd0);
        check("reset addr_mode", 32'(addr_mode), 32'd0);
        check("reset wrdata", 32'(wrdata), 32'd0);
        check("reset device_id", 32'(device_id), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset dly_cnt_max", dly_cnt_max, DLYD);
        Rst_n = 1'b1;
        repeat (2) @(posedge Clk);
        #1;

        f = {8'hA5, 8'h00, 8'hA0, 8'h00, 8'h3C, 8'h7F, 8'hE3};
        model_frame(f, 1'b0, 8'h00, 3);
        send_frame(f);
        wait_idle("write8");

        f = {8'hA5, 8'h03, 8'hA0, 8'h12, 8'h34, 8'h85};
        model_frame(f, 1'b0, 8'hC6, 30);
        send_frame(f);
        t = 0;
        while (!rsp_wait && t < 50) begin
            @(posedge Clk); #1;
            t++;
        end
        if (t >= 50) fail("read16 request never reached responder");
        send_byte(8'hA5, 2);
        wait_idle("read16 ok");

        model_frame(f, 1'b1, 8'hC6, 2);
        send_frame(f);
        wait_idle("read16 nack");

        f = {8'hA5, 8'h00, 8'hA0, 8'h00, 8'h3C, 8'h7F, 8'h00};
        model_frame(f, 1'b0, 8'h00, 0);
        send_frame(f);
        wait_idle("checksum error");

        f = {8'hA5, 8'h08};
        model_frame(f, 1'b0, 8'h00, 0);
        send_frame(f);
        wait_idle("bad command");
        f = {8'hA5, 8'h02, 8'h44, 8'hBE, 8'hEF, 8'h11, 8'h00};
        f[6] = f[1] ^ f[2] ^ f[3] ^ f[4] ^ f[5];
        model_frame(f, 1'b0, 8'h00, 1);
        send_frame(f);
        wait_idle("write after bad command");

        f = {8'hA5, 8'h04, 8'h00, 8'h00, 8'h01, 8'hF4, 8'hF1};
        old = m_dly;
        model_frame(f, 1'b0, 8'h00, 0);
        for (int i = 0; i < 6; i++) send_byte(f[i], 1);
        check("dly before cfg chk", dly_cnt_max, old);
        send_byte(f[6], 0);
        check("dly after cfg chk", dly_cnt_max, m_dly);
        wait_idle("cfg");
        check("dly cfg value", dly_cnt_max, 32'h0000_01F4);

        stray_req++;
        repeat (10) @(posedge Clk);
        #1;
        check("stray RW_Done ignored", 32'(busy), 32'd0);

        send_byte(8'hA5, 0);
        send_byte(8'h00, 0);
        send_byte(8'hA0, 0);
        repeat (TMO - 1) @(posedge Clk);
        #1;
        check("busy before timeout", 32'(busy), 32'd1);
        @(posedge Clk); #1;
        check("timeout back to hunt", 32'(busy), 32'd0);
        repeat (10) @(posedge Clk);
        #1;
        check("no tx after timeout", 32'(exp_tx.size()), 32'd0);

        bp_mode = 1'b1;
        f = {8'hA5, 8'h01, 8'h3E, 8'h99, 8'h07, 8'h00};
        f[5] = f[1] ^ f[2] ^ f[3] ^ f[4];
        model_frame(f, 1'b0, 8'h5C, 4);
        send_frame(f);
        wait_idle("backpressure read");
        bp_mode = 1'b0;

        for (int i = 0; i < 60; i++) begin
            repeat ($urandom_range(0, 2)) begin
                g = 8'($urandom);
                if (g == 8'hA5) g = 8'h00;
                send_byte(g, 1);
            end
            kind = $urandom_range(0, 4);
            build(kind, f);
            model_frame(f, 1'($urandom), 8'($urandom), $urandom_range(0, 8));
            send_frame(f);
            wait_idle("random frame");
            if (kind == 2) check("random cfg dly", dly_cnt_max, m_dly);
        end

        send_byte(8'hA5, 0);
        send_byte(8'h03, 0);
        send_byte(8'hA0, 0);
        #2;
        Rst_n = 1'b0;
        #1;
        m_dly = DLYD;
        check("mid-frame reset busy", 32'(busy), 32'd0);
        check("mid-frame reset dly", dly_cnt_max, m_dly);
        repeat (2) @(posedge Clk);
        #1;
        Rst_n = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        build(0, f);
        model_frame(f, 1'b0, 8'h00, 2);
        send_frame(f);
        wait_idle("write after reset");

        check("tx queue empty", 32'(exp_tx.size()), 32'd0);
        check("plan queue empty", 32'(plans.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
